// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Holds FSM state encodings and op-select codes.
package serial_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_fa.sv
// serial_fa_cell: pure combinational 1-bit full adder.
// Ports: a, b, cin in; s (sum), co (carry out) out.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial A+B / A-B sequencer, LSB first, one
// bit per clock through a single full-adder cell.
// Ports: clk, rst (sync, active-high), start, m (0=add,1=sub), a_in,
//   b_in in; ready, busy, done, result, cout, ovf out.
// Macro ADDSUB_OVF_EN: builds the signed-overflow register; otherwise
//   ovf is tied to 0.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;

  logic fa_a, fa_b, fa_s, fa_co;
  logic last;

  assign last = (cnt_q == CNTW'(WIDTH - 1));
  assign fa_a = a_q[cnt_q];
  // Subtract is A + ~B + 1: invert B here, the +1 is the initial carry.
  assign fa_b = b_q[cnt_q] ^ (m_q == OP_SUB);

  serial_fa_cell u_fa (
    .a  (fa_a),
    .b  (fa_b),
    .cin(carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    m_d     = m_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          m_d     = m;
          cnt_d   = '0;
          carry_d = (m != OP_ADD);
          res_d   = '0;
`ifdef ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[cnt_q] = fa_s;
        carry_d      = fa_co;
        cnt_d        = cnt_q + CNTW'(1);
        if (last) begin
          cout_d  = fa_co;
`ifdef ADDSUB_OVF_EN
          // carry_q is the carry into the MSB on the last bit.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      m_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign cout   = cout_q;
`ifdef ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl at WIDTH=4.
// Vector table + scoreboard queue checked on every done pulse.
module tb_serial_addsub_ctrl;

  localparam int W = 4;
`ifdef ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         m = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] result;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m),
    .a_in(a_in), .b_in(b_in), .ready(ready), .busy(busy),
    .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done && !rst) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", int'(result), int'(e.res));
        chk("sb_cout", int'(cout), int'(e.co));
        chk("sb_ovf", int'(ovf), OVF_EN ? int'(e.ov) : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic mm, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0] s;
    bb = mm ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, mm};
    e.res = s[W-1:0];
    e.co = s[W];
    e.ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 30) begin
      tick();
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_op(input logic mm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    int n = 0;
    wait_ready();
    m = mm;
    a_in = a;
    b_in = b;
    start = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    chk("acc_clear", int'(result), 0);
    chk("acc_busy", int'(busy), 1);
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, W);
    tick();
    tick();
    chk("hold_result", int'(result), int'(e.res));
    chk("hold_cout", int'(cout), int'(e.co));
  endtask

  initial begin
    int dn, cyc, last, base;
    exp_t e;

    tbl[0] = '{1'b0, 4'd5, 4'd3, 4'd8, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 4'd15, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'd3, 4'd5, 4'd14, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'd8, 4'd1, 4'd7, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'd7, 4'd7, 4'd14, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);

    for (int i = 0; i < 7; i++) begin
      e.res = tbl[i].res;
      e.co = tbl[i].co;
      e.ov = tbl[i].ov;
      run_op(tbl[i].m, tbl[i].a, tbl[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      logic mm;
      logic [W-1:0] a, b;
      mm = 1'($urandom_range(1));
      a = W'($urandom_range(15));
      b = W'($urandom_range(15));
      run_op(mm, a, b, model(mm, a, b));
    end

    // start re-pulsed during RUN must be ignored
    wait_ready();
    base = done_cnt;
    m = 1'b0; a_in = 4'd1; b_in = 4'd1; start = 1'b1;
    e.res = 4'd2; e.co = 1'b0; e.ov = 1'b0;
    sb.push_back(e);
    tick();
    a_in = 4'd7; b_in = 4'd7;
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < W + 6; i++) tick();
    chk("busy_one_done", done_cnt - base, 1);
    chk("busy_result", int'(result), 2);

    // start held: one op every W+2 cycles
    wait_ready();
    m = 1'b0; a_in = 4'd2; b_in = 4'd3; start = 1'b1;
    e.res = 4'd5; e.co = 1'b0; e.ov = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back(e);
    dn = 0; cyc = 0; last = -1;
    while (dn < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        if (last < 0) chk("held_first", cyc, W + 1);
        else chk("held_period", cyc - last, W + 2);
        last = cyc;
        dn++;
        if (dn == 3) start = 1'b0;
      end else if (ready && dn < 3) begin
        chk("held_ready_gap", cyc - last, 1);
      end
    end
    chk("held_count", dn, 3);
    tick();
    tick();

    // reset in the 2nd RUN cycle abandons the op
    wait_ready();
    base = done_cnt;
    m = 1'b0; a_in = 4'd1; b_in = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_result", int'(result), 0);
    chk("midrst_busy", int'(busy), 0);
    for (int i = 0; i < W + 4; i++) tick();
    chk("midrst_no_done", done_cnt - base, 0);
    run_op(1'b0, 4'd6, 4'd1, model(1'b0, 4'd6, 4'd1));

    // rst and start together: nothing accepted
    base = done_cnt;
    rst = 1'b1; start = 1'b1; a_in = 4'd9; b_in = 4'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("coll_ready", int'(ready), 1);
    chk("coll_busy", int'(busy), 0);
    for (int i = 0; i < W + 4; i++) tick();
    chk("coll_no_done", done_cnt - base, 0);
    chk("coll_result", int'(result), 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
